pipe_chain: RTL and testbench
=============================

Name: pipe_chain

Overview:
- Parametrised elastic pipeline-register chain, the successor to the fixed single-stage pipeline register used between CPU stages.
- Carries a WIDTH-bit payload through DEPTH register stages.
- Each stage has a valid bit, with bubble-collapsing ready/valid flow control, global stall and per-stage flush.
- Used as the inter-stage transport for the hazard-aware pipelined CPU: stall on load-use, flush on taken branch.

Parameters:
WIDTH, 32, payload bits per stage
DEPTH, 4, number of register stages (>=1)
OCC_W, 3, occupancy width; must satisfy 2**OCC_W > DEPTH

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
in_valid_i  in  1  upstream payload valid
in_ready_o  out  1  chain can accept in_data_i this cycle
in_data_i  in  WIDTH  upstream payload
out_valid_o  out  1  stage DEPTH-1 holds valid payload, and no stall
out_ready_i  in  1  downstream accepts
out_data_o  out  WIDTH  stage DEPTH-1 payload
stall_i  in  1  global hold: freezes all stages
flush_i  in  DEPTH  bit k kills stage k contents at next edge
occupancy_o  out  OCC_W  number of valid stages

Behaviour:
- Reset: one clock (clk_i); rst_i is asynchronous and active-high.
  - All valid bits clear and all data registers clear to 0 immediately on rst_i high.
  - Resulting outputs: out_valid_o=0, out_data_o=0, occupancy_o=0, in_ready_o=1 (when stall_i=0).
- Stage state: valid[k], data[k], k=0..DEPTH-1. Stage 0 is nearest the input.
- Ready chain (combinational):
  - rdy[DEPTH] = out_ready_i.
  - rdy[k] = !valid[k] | rdy[k+1].
  - in_ready_o = rdy[0] & !stall_i.
  - out_valid_o = valid[DEPTH-1] & !stall_i.
- Advance, when stall_i=0:
  - Stage k loads from stage k-1 (stage 0 loads from the input) when rdy[k]=1.
  - The loaded valid equals the source valid; data loads only when the source valid is 1, otherwise data holds.
  - Stage DEPTH-1 empties when out_ready_i=1 and nothing valid enters behind it.
- Bubble collapse: a valid stage with an empty successor moves forward even if downstream is blocked.
- Latency: DEPTH cycles from input to output when unblocked. Throughput is 1 payload/cycle.
- Stall (stall_i=1):
  - No stage changes except by flush.
  - No transfer occurs at either end: in_ready_o=0, out_valid_o=0.
- Flush:
  - flush_i[k]=1 forces valid[k]=0 after the edge, regardless of stall_i or of any payload moving into stage k.
  - A payload leaving stage k in the same cycle still lands in stage k+1 unless flush_i[k+1]=1.
  - Data registers are not cleared by flush.
- Simultaneous events:
  - flush beats stall, and flush beats load.
  - An output transfer and an input transfer may occur in the same cycle.
- occupancy_o: population count of valid[] (combinational from registers).
- Ordering: payloads never reorder or duplicate; a payload is lost only by flush or reset.
- Reset mid-operation: all in-flight payloads are discarded immediately, with no partial transfer.

Optional Feature:
- Macro: PIPE_CHAIN_PERF_EN.
- With the macro defined, two extra outputs are added:
  - stall_cnt_o (32): increments each cycle stall_i=1.
  - bubble_cnt_o (32): increments each cycle out_ready_i=1, out_valid_o=0 and stall_i=0.
  - Both saturate at 32'hFFFFFFFF and clear on rst_i.
- Without the macro, these ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Reset then stream: DEPTH=4, in_valid_i=1, data 1,2,3,… with out_ready_i=1 -> first out_valid_o at cycle 4 with data 1, then one word per cycle in order; occupancy_o steady at 4.
- Backpressure and collapse: load 2 words with gaps of 1 idle cycle, out_ready_i=0 -> both compact to stages 3 and 2; in_ready_o stays 1 until 4 words are held, then 0; occupancy_o=4.
- Stall: with 3 valid words, stall_i=1 for 5 cycles -> valid/data unchanged, in_ready_o=0, out_valid_o=0; on release, output resumes with the same word.
- Flush under stall: stages 0–2 valid, stall_i=1, flush_i=4'b0011 -> after the edge occupancy_o=1; only the stage-2 payload ever emerges.
- Flush vs. load: flush_i[0]=1 while in_valid_i=1, in_ready_o=1 -> the input word is dropped and valid[0]=0 next cycle.
- Async reset mid-stream: assert rst_i between edges with 4 valid words -> out_valid_o and occupancy_o go to 0 before the next clock edge; after release, the chain restarts cleanly.

Source files
------------

// File: rtl/pipe_chain.sv
// pipe_chain: elastic pipeline-register chain with valid bits per stage.
//
// Moves a WIDTH-bit payload through DEPTH register stages. Empty stages
// collapse: a valid stage moves forward into an empty successor even
// when the downstream consumer is blocked. The chain also has a global
// stall and a per-stage flush.
//
// Optional feature macro: PIPE_CHAIN_PERF_EN. When it is defined, the
// stall and bubble performance counters are added.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous, active-high reset
//   in_valid_i   upstream payload valid
//   in_ready_o   chain accepts in_data_i this cycle
//   in_data_i    upstream payload
//   out_valid_o  last stage holds a valid payload and no stall
//   out_ready_i  downstream accepts
//   out_data_o   last stage payload
//   stall_i      global hold; every stage freezes, flush still applies
//   flush_i      bit k clears the valid bit of stage k at the next edge
//   occupancy_o  number of valid stages
//   stall_cnt_o  (PIPE_CHAIN_PERF_EN) cycles with stall_i high, saturating
//   bubble_cnt_o (PIPE_CHAIN_PERF_EN) cycles the consumer waited on an
//                empty output, saturating

// One stage: a valid bit and a data register.
module pipe_chain_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             flush,
   input  logic             ld,
   input  logic             src_vld,
   input  logic [WIDTH-1:0] src_data,
   output logic             vld,
   output logic [WIDTH-1:0] data
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld  <= 1'b0;
         data <= '0;
      end else begin
         if (!stall && ld) begin
            vld <= src_vld;
            // A bubble moving in keeps the old data, so idle stages do not toggle.
            if (src_vld) data <= src_data;
         end
         // The flush is written last, so it wins over both the load and the stall.
         if (flush) vld <= 1'b0;
      end
   end
endmodule

module pipe_chain #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int OCC_W = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_data_o,
   input  logic             stall_i,
   input  logic [DEPTH-1:0] flush_i,
   output logic [OCC_W-1:0] occupancy_o
`ifdef PIPE_CHAIN_PERF_EN
   ,
   output logic [31:0]      stall_cnt_o,
   output logic [31:0]      bubble_cnt_o
`endif
);
   logic [DEPTH:0]                rdy;
   logic [DEPTH-1:0]              vld_pipe;
   logic [DEPTH-1:0][WIDTH-1:0]   data_pipe;
   logic [DEPTH-1:0]              src_vld;
   logic [DEPTH-1:0][WIDTH-1:0]   src_data;

   // The ready signal ripples back from the output. A stage can take new
   // data when it is empty, or when its own contents are leaving this cycle.
   always_comb begin
      rdy        = '0;
      rdy[DEPTH] = out_ready_i;
      for (int k = DEPTH - 1; k >= 0; k--)
         rdy[k] = !vld_pipe[k] | rdy[k+1];
   end

   assign in_ready_o  = rdy[0] & !stall_i;
   assign out_valid_o = vld_pipe[DEPTH-1] & !stall_i;
   assign out_data_o  = data_pipe[DEPTH-1];

   for (genvar k = 0; k < DEPTH; k++) begin : g_stg
      if (k == 0) begin : g_src_in
         assign src_vld[k]  = in_valid_i;
         assign src_data[k] = in_data_i;
      end else begin : g_src_prev
         assign src_vld[k]  = vld_pipe[k-1];
         assign src_data[k] = data_pipe[k-1];
      end

      pipe_chain_stage #(.WIDTH(WIDTH)) u_stg (
         .clk      (clk_i),
         .rst      (rst_i),
         .stall    (stall_i),
         .flush    (flush_i[k]),
         .ld       (rdy[k]),
         .src_vld  (src_vld[k]),
         .src_data (src_data[k]),
         .vld      (vld_pipe[k]),
         .data     (data_pipe[k])
      );
   end

   always_comb begin
      occupancy_o = '0;
      for (int k = 0; k < DEPTH; k++)
         occupancy_o = occupancy_o + OCC_W'(vld_pipe[k]);
   end

`ifdef PIPE_CHAIN_PERF_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_cnt_o  <= '0;
         bubble_cnt_o <= '0;
      end else begin
         if (stall_i && stall_cnt_o != '1)
            stall_cnt_o <= stall_cnt_o + 32'd1;
         if (out_ready_i && !out_valid_o && !stall_i && bubble_cnt_o != '1)
            bubble_cnt_o <= bubble_cnt_o + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_pipe_chain.sv
// Directed testbench for pipe_chain (WIDTH=32, DEPTH=4), default build.
module tb_pipe_chain;
   logic        clk;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready, stall;
   logic [31:0] in_data, out_data;
   logic [3:0]  flush;
   logic [2:0]  occ;
   int          nvec = 0;
   int          nerr = 0;

   pipe_chain #(.WIDTH(32), .DEPTH(4), .OCC_W(3)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_data_i   (in_data),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_data),
      .stall_i     (stall),
      .flush_i     (flush),
      .occupancy_o (occ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      nvec++;
      if (obs !== exp_v) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
      end
   endtask

   // Wait for the next active edge, then move 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] exp_q [4];

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      stall = 1'b0; flush = '0;
      tick();
      chk("rst_ovld", out_valid, 0);
      chk("rst_odata", out_data, 0);
      chk("rst_occ", occ, 0);
      chk("rst_irdy", in_ready, 1);
      rst = 1'b0;

      // Reset then stream: first output after 4 edges, one word per cycle.
      out_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         in_valid = 1'b1; in_data = 32'(c + 1);
         #1;
         chk("t1_ovld", out_valid, (c >= 4) ? 1 : 0);
         if (c >= 4) chk("t1_data", out_data, 32'(c - 3));
         chk("t1_occ", occ, (c < 4) ? 32'(c) : 4);
         chk("t1_irdy", in_ready, 1);
         tick();
      end
      in_valid = 1'b0;
      for (int d = 0; d < 5; d++) begin
         #1;
         chk("t1d_ovld", out_valid, (d < 4) ? 1 : 0);
         if (d < 4) chk("t1d_data", out_data, 32'(9 + d));
         chk("t1d_occ", occ, 32'(4 - d));
         tick();
      end

      // Backpressure and collapse.
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'hA0; tick();
      in_valid = 1'b0; tick();
      in_valid = 1'b1; in_data = 32'hB0; tick();
      in_valid = 1'b0; tick(); tick(); tick();
      #1;
      chk("t2_ovld", out_valid, 1);
      chk("t2_data", out_data, 32'hA0);
      chk("t2_occ2", occ, 2);
      chk("t2_irdy2", in_ready, 1);
      in_valid = 1'b1; in_data = 32'hC0;
      #1; chk("t2_irdyC", in_ready, 1);
      tick();
      in_data = 32'hD0;
      #1; chk("t2_irdyD", in_ready, 1); chk("t2_occ3", occ, 3);
      tick();
      in_data = 32'hE0;
      #1; chk("t2_irdy4", in_ready, 0); chk("t2_occ4", occ, 4);
      chk("t2_headA", out_data, 32'hA0);
      tick();
      #1; chk("t2_hold_occ", occ, 4); chk("t2_hold_irdy", in_ready, 0);
      out_ready = 1'b1;
      #1; chk("t2_rel_irdy", in_ready, 1); chk("t2_rel_data", out_data, 32'hA0);
      tick();
      in_valid = 1'b0;
      exp_q = '{32'hB0, 32'hC0, 32'hD0, 32'hE0};
      for (int j = 0; j < 4; j++) begin
         #1;
         chk("t2_drain_vld", out_valid, 1);
         chk("t2_drain_data", out_data, exp_q[j]);
         tick();
      end
      #1; chk("t2_empty", occ, 0);

      // Stall with three words held.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = 32'(32'h100 + i); tick();
      end
      in_valid = 1'b0; tick();
      stall = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t3_irdy", in_ready, 0);
         chk("t3_ovld", out_valid, 0);
         chk("t3_occ", occ, 3);
         chk("t3_data", out_data, 32'h100);
         tick();
      end
      stall = 1'b0; in_valid = 1'b0;
      for (int j = 0; j < 3; j++) begin
         #1;
         chk("t3_res_vld", out_valid, 1);
         chk("t3_res_data", out_data, 32'(32'h100 + j));
         tick();
      end
      #1; chk("t3_empty", occ, 0);

      // Flush under stall: stages 0-1 are killed, stage 2 survives.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = 32'(32'h200 + i); tick();
      end
      in_valid = 1'b0;
      #1; chk("t4_occ3", occ, 3);
      stall = 1'b1; flush = 4'b0011; tick();
      flush = '0;
      #1; chk("t4_occ1", occ, 1);
      stall = 1'b0; out_ready = 1'b1;
      #1; chk("t4_ovld0", out_valid, 0);
      tick();
      #1; chk("t4_ovld", out_valid, 1); chk("t4_data", out_data, 32'h200);
      chk("t4_occ", occ, 1);
      tick();
      for (int i = 0; i < 3; i++) begin
         #1; chk("t4_none_vld", out_valid, 0); chk("t4_none_occ", occ, 0);
         tick();
      end

      // Flush beats load at stage 0.
      in_valid = 1'b1; in_data = 32'h55; flush = 4'b0001;
      #1; chk("t5_irdy", in_ready, 1);
      tick();
      flush = '0; in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1; chk("t5_occ", occ, 0); chk("t5_ovld", out_valid, 0);
         tick();
      end
      // A payload leaving a flushed stage still lands in the next one.
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h66; tick();
      in_valid = 1'b0; flush = 4'b0001; tick();
      flush = '0; out_ready = 1'b1;
      #1; chk("t5_mv_occ", occ, 1);
      tick(); tick();
      #1; chk("t5_mv_vld", out_valid, 1); chk("t5_mv_data", out_data, 32'h66);
      tick();
      #1; chk("t5_mv_empty", occ, 0);

      // Asynchronous reset between edges while the chain is full.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = 32'(32'h300 + i); tick();
      end
      in_valid = 1'b0;
      #1; chk("t6_occ4", occ, 4); chk("t6_vld", out_valid, 1);
      #1; rst = 1'b1;
      #1;
      chk("t6_rst_vld", out_valid, 0);
      chk("t6_rst_occ", occ, 0);
      chk("t6_rst_data", out_data, 0);
      #2; rst = 1'b0;
      tick();
      #1; chk("t6_post_occ", occ, 0); chk("t6_post_irdy", in_ready, 1);
      out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h77; tick();
      in_valid = 1'b0; tick(); tick(); tick();
      #1; chk("t6_re_vld", out_valid, 1); chk("t6_re_data", out_data, 32'h77);
      chk("t6_re_occ", occ, 1);
      tick();
      #1; chk("t6_re_empty", occ, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
